// File: rtl/mmwave_frame_sequencer.sv
// mmwave_frame_sequencer
// Captures a frame of chirps from a down-sampled ADC stream and forwards the
// samples, tagged with frame/chirp sideband, through an output FIFO.
//
// Ports
//   clk, rst          : system clock, asynchronous active-high reset
//   en_i              : level enable; a frame that has started always completes
//   chirp_num_i       : chirps per frame (0 treated as 1), latched at frame start
//   chirp_len_i       : samples per chirp (0 treated as 1), latched at frame start
//   frame_gap_i       : idle cycles after each frame, latched at frame start
//   chirp_start_i     : single-cycle pulse marking the start of a chirp
//   sample_valid_i    : ADC sample strobe
//   sample_data_i     : ADC sample
//   out_valid_o       : output beat available
//   out_ready_i       : downstream accepts the beat
//   out_data_o        : sample data
//   out_sof_o         : first sample of the frame
//   out_eof_o         : last sample of the frame
//   out_chirp_idx_o   : chirp index of the sample
//   busy_o            : sequencer is not idle
//   frame_done_o      : one-cycle pulse after the last sample of a frame
//   overflow_o        : sticky, set when a sample was dropped on a full FIFO
//   state_dbg         : current FSM state (0 IDLE, 1 WAIT_CHIRP, 2 CAPTURE, 3 GAP)
//
// Handshake: a beat transfers on every rising clk edge where out_valid_o and
// out_ready_i are both 1; while out_valid_o=1 and out_ready_i=0 the data and
// sideband hold stable and out_valid_o stays high.

module mmwave_frame_sequencer #(
  parameter int DATA_W     = 13,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [4:0]        chirp_num_i,
  input  logic [15:0]       chirp_len_i,
  input  logic [31:0]       frame_gap_i,
  input  logic              chirp_start_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sof_o,
  output logic              out_eof_o,
  output logic [4:0]        out_chirp_idx_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overflow_o,
  output logic [1:0]        state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 7;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  num_l;
  logic [15:0] len_l;
  logic [31:0] gap_l;
  logic [4:0]  chirp_idx;
  logic [15:0] sample_cnt;
  logic [31:0] gap_cnt;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Zero-valued configuration is promoted to 1 when latched.
  logic [4:0]  num_eff;
  logic [15:0] len_eff;
  assign num_eff = (chirp_num_i == 5'd0) ? 5'd1 : chirp_num_i;
  assign len_eff = (chirp_len_i == 16'd0) ? 16'd1 : chirp_len_i;

  logic last_sample, final_chirp, sof, eof;
  assign last_sample = (sample_cnt == len_l - 16'd1);
  assign final_chirp = (chirp_idx == num_l - 5'd1);
  assign sof         = (sample_cnt == 16'd0) && (chirp_idx == 5'd0);
  assign eof         = last_sample && final_chirp;

  logic full, push_req, push, pop;
  assign full     = (count == DEPTH_C);
  assign push_req = (state == S_CAPTURE) && sample_valid_i;
  // A full FIFO rejects the push even if a pop happens in the same cycle.
  assign push     = push_req && !full;
  assign pop      = out_valid_o && out_ready_i;

  logic [EW-1:0] entry;
  assign entry = {sample_data_i, sof, eof, chirp_idx};

  // Sequencer FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      num_l        <= 5'd0;
      len_l        <= 16'd0;
      gap_l        <= 32'd0;
      chirp_idx    <= 5'd0;
      sample_cnt   <= 16'd0;
      gap_cnt      <= 32'd0;
      frame_done_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en_i) begin
            num_l <= num_eff;
            len_l <= len_eff;
            gap_l <= frame_gap_i;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Once chirp 0 has been captured the frame must finish.
          if (!en_i && chirp_idx == 5'd0) begin
            state <= S_IDLE;
          end else if (chirp_start_i) begin
            sample_cnt <= 16'd0;
            state      <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sample_valid_i) begin
            if (last_sample) begin
              sample_cnt <= 16'd0;
              if (final_chirp) begin
                frame_done_o <= 1'b1;
                gap_cnt      <= gap_l;
                chirp_idx    <= 5'd0;
                state        <= S_GAP;
              end else begin
                chirp_idx <= chirp_idx + 5'd1;
                state     <= S_WAIT;
              end
            end else begin
              sample_cnt <= sample_cnt + 16'd1;
            end
          end
        end
        S_GAP: begin
          // GAP lasts frame_gap cycles, with a minimum of one.
          if (gap_cnt <= 32'd1) begin
            gap_cnt <= 32'd0;
            if (en_i) begin
              num_l <= num_eff;
              len_l <= len_eff;
              gap_l <= frame_gap_i;
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (push_req && full) overflow_o <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // The head entry is read straight from storage flops; outputs are forced to
  // zero while nothing is buffered so reset clears them immediately.
  logic [EW-1:0] head;
  assign head            = mem[rd_ptr];
  assign out_valid_o     = (count != '0);
  assign out_data_o      = out_valid_o ? head[EW-1 -: DATA_W] : '0;
  assign out_sof_o       = out_valid_o & head[6];
  assign out_eof_o       = out_valid_o & head[5];
  assign out_chirp_idx_o = out_valid_o ? head[4:0] : 5'd0;
  assign busy_o          = (state != S_IDLE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_mmwave_frame_sequencer.sv
module tb_mmwave_frame_sequencer;
  localparam int DW = 13;
  localparam int W  = DW + 7;

  logic          clk;
  logic          rst;
  logic          en_i;
  logic [4:0]    chirp_num_i;
  logic [15:0]   chirp_len_i;
  logic [31:0]   frame_gap_i;
  logic          chirp_start_i;
  logic          sample_valid_i;
  logic [DW-1:0] sample_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic          out_sof_o;
  logic          out_eof_o;
  logic [4:0]    out_chirp_idx_o;
  logic          busy_o;
  logic          frame_done_o;
  logic          overflow_o;
  logic [1:0]    state_dbg;

  mmwave_frame_sequencer #(.DATA_W(DW), .FIFO_DEPTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_i            (en_i),
    .chirp_num_i     (chirp_num_i),
    .chirp_len_i     (chirp_len_i),
    .frame_gap_i     (frame_gap_i),
    .chirp_start_i   (chirp_start_i),
    .sample_valid_i  (sample_valid_i),
    .sample_data_i   (sample_data_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_data_o      (out_data_o),
    .out_sof_o       (out_sof_o),
    .out_eof_o       (out_eof_o),
    .out_chirp_idx_o (out_chirp_idx_o),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o),
    .overflow_o      (overflow_o),
    .state_dbg       (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int rdy_mode = 0;       // 0 always ready, 1 random, 2 never ready
  int gap_cycles = 0;
  int done_pulses = 0;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_out = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
    end
  endfunction

  // ---------------- ready driver ----------------
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ($urandom_range(0, 3) != 0);
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      cur = {out_data_o, out_sof_o, out_eof_o, out_chirp_idx_o};
      if (prev_stall) chk("stall_hold", {out_valid_o, cur}, {1'b1, prev_out});
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%0h expected=none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", cur, e);
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_out   = cur;
      if (state_dbg == 2'd3) gap_cycles++;
      if (frame_done_o) done_pulses++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sv, input logic cs, input logic [DW-1:0] d);
    sample_valid_i = sv;
    chirp_start_i  = cs;
    sample_data_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (state_dbg != 2'd0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_reached", {62'd0, state_dbg}, 64'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid_o) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_q_empty", exp_q.size(), 0);
  endtask

  // One frame: num/len/gap as programmed, chirp 0 forced to start with a
  // simultaneous sample when overlap0 is set, en dropped after the first
  // sample when drop_en is set, and early exit after abort_after samples of
  // chirp 0 when abort_after >= 0.
  task automatic do_frame(input int num, input int len, input int gap,
                          input bit drop_en, input int abort_after, input bit overlap0);
    int num_e, len_e, sent, accepted, exp_gap;
    logic v, cs, ov;
    logic [DW-1:0] d;
    num_e    = (num == 0) ? 1 : num;
    len_e    = (len == 0) ? 1 : len;
    exp_gap  = (gap == 0) ? 1 : gap;
    accepted = 0;
    chirp_num_i = 5'(num);
    chirp_len_i = 16'(len);
    frame_gap_i = 32'(gap);
    en_i = 1'b1;
    gap_cycles  = 0;
    done_pulses = 0;
    drive(1'b0, 1'b0, '0);
    chk("busy_in_frame", {63'd0, busy_o}, 64'd1);
    // Config changes after the frame has started must have no effect.
    chirp_num_i = 5'($urandom);
    chirp_len_i = 16'($urandom);
    frame_gap_i = 32'($urandom_range(0, 50));
    for (int c = 0; c < num_e; c++) begin
      repeat ($urandom_range(0, 2)) drive(1'($urandom_range(0, 1)), 1'b0, DW'($urandom));
      ov = (overlap0 && c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      drive(ov, 1'b1, DW'($urandom));
      sent = 0;
      while (sent < len_e) begin
        v  = ($urandom_range(0, 3) != 0);
        cs = ($urandom_range(0, 7) == 0);
        d  = DW'($urandom);
        if (v) begin
          if (rdy_mode != 2 || accepted < 16) begin
            exp_q.push_back({d, (c == 0 && sent == 0), (c == num_e - 1 && sent == len_e - 1), 5'(c)});
            accepted++;
          end
          sent++;
        end
        drive(v, cs, d);
        if (drop_en && c == 0 && sent == 1) en_i = 1'b0;
        if (abort_after >= 0 && c == 0 && sent == abort_after) begin
          sample_valid_i = 1'b0;
          chirp_start_i  = 1'b0;
          return;
        end
      end
    end
    sample_valid_i = 1'b0;
    chirp_start_i  = 1'b0;
    en_i = 1'b0;
    wait_idle(exp_gap + 20);
    chk("gap_cycles", gap_cycles, exp_gap);
    chk("frame_done_pulses", done_pulses, 1);
    chk("busy_after_frame", {63'd0, busy_o}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, l;
    rst = 1'b1;
    en_i = 1'b0;
    chirp_num_i = '0;
    chirp_len_i = '0;
    frame_gap_i = '0;
    chirp_start_i = 1'b0;
    sample_valid_i = 1'b0;
    sample_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done_o}, 64'd0);
    chk("rst_overflow", {63'd0, overflow_o}, 64'd0);
    chk("rst_state", {62'd0, state_dbg}, 64'd0);
    chk("rst_out_data", {51'd0, out_data_o}, 64'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);

    // Basic 2x4 frame, gap 10
    rdy_mode = 0;
    do_frame(2, 4, 10, 1'b0, -1, 1'b0);
    wait_drain();

    // chirp_start coincident with a sample
    do_frame(1, 4, 3, 1'b0, -1, 1'b1);
    wait_drain();

    // zero config promoted to 1
    do_frame(0, 0, 0, 1'b0, -1, 1'b0);
    wait_drain();

    // en dropped during chirp 0 of a 3-chirp frame
    do_frame(3, 3, 2, 1'b1, -1, 1'b0);
    wait_drain();

    // randomized frames under random backpressure, at most 16 samples each
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(0, 4);
      l = $urandom_range(0, 16 / ((n == 0) ? 1 : n));
      do_frame(n, l, $urandom_range(0, 12), 1'b0, -1, 1'b0);
      wait_drain();
    end
    chk("no_overflow_yet", {63'd0, overflow_o}, 64'd0);

    // overflow: 20 samples with no consumer
    rdy_mode = 2;
    do_frame(1, 20, 2, 1'b0, -1, 1'b0);
    chk("overflow_set", {63'd0, overflow_o}, 64'd1);
    chk("buffered_valid", {63'd0, out_valid_o}, 64'd1);
    chk("buffered_count", exp_q.size(), 16);
    rdy_mode = 0;
    wait_drain();
    chk("overflow_sticky", {63'd0, overflow_o}, 64'd1);

    // reset in the middle of CAPTURE
    rdy_mode = 2;
    do_frame(2, 4, 1, 1'b0, 3, 1'b0);
    chk("in_capture", {62'd0, state_dbg}, 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("async_rst_data", {51'd0, out_data_o}, 64'd0);
    chk("async_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("async_rst_overflow", {63'd0, overflow_o}, 64'd0);
    chk("async_rst_state", {62'd0, state_dbg}, 64'd0);
    exp_q.delete();
    en_i = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    do_frame(2, 4, 5, 1'b0, -1, 1'b0);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog
  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
